lag_credit_link: RTL and testbench



---
 rtl/lag_link_pkg.sv | 12 +
 rtl/lag_delay_line.sv | 59 +++++
 rtl/lag_credit_link.sv | 109 ++++++++++
 tb/tb_lag_credit_link.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lag_link_pkg.sv
// Shared definitions for the LAG mesh router-to-router link.
//   LINK_MAX_STAGES : deepest forward or credit pipeline a link may be built with.
//   cnt_width()     : width of a per-lane credit counter that must hold 0..buf_len.
package lag_link_pkg;

    localparam int unsigned LINK_MAX_STAGES = 8;

    function automatic int unsigned cnt_width(input int unsigned buf_len);
        return $clog2(buf_len + 1);
    endfunction

endpackage

// File: rtl/lag_delay_line.sv
// Resettable DEPTH-stage register chain carrying a valid bit and a data word.
// Data registers load only when the valid entering that stage is 1, so bubbles
// clear the valid without disturbing the stored data. DEPTH = 0 is a plain wire.
// W = 0 gives a valid-only line; a 1-bit data path is kept for a legal port
// width, and the caller ties it to zero.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : valid entering stage 0
//   in_data    : data entering stage 0
//   out_valid  : valid leaving the last stage
//   out_data   : data leaving the last stage
module lag_delay_line #(
    parameter  int unsigned W     = 1,
    parameter  int unsigned DEPTH = 1,
    localparam int unsigned DW    = (W > 0) ? W : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    if (DEPTH == 0) begin : g_wire
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld_q, vld_d;
        logic [DW-1:0]    dat_q [DEPTH];
        logic [DW-1:0]    dat_d [DEPTH];

        always_comb begin
            vld_d[0] = in_valid;
            dat_d[0] = in_valid ? in_data : dat_q[0];
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end

        assign out_valid = vld_q[DEPTH-1];
        assign out_data  = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/lag_credit_link.sv
// Pipelined LAG mesh link: NPL independent lanes of flits through a STAGES-deep
// forward pipe, per-lane credits back through a CR_STAGES-deep return pipe, and
// an upstream credit counter per lane that drives up_ready directly.
//   clk, rst_n : clock, synchronous active-low reset
//   up_flit    : upstream flits, lane l at [l*FLIT_W +: FLIT_W]
//   up_valid   : upstream flit present per lane
//   up_ready   : lane has at least one credit (registered decode, no path from up_valid)
//   dn_flit    : delayed flits, same packing as up_flit
//   dn_valid   : delayed valid per lane
//   dn_credit  : downstream freed one buffer slot on the lane this cycle
//   err        : sticky per-lane protocol error (send without credit, credit overflow)
module lag_credit_link
    import lag_link_pkg::*;
#(
    parameter int unsigned NPL       = 2,
    parameter int unsigned FLIT_W    = 64,
    parameter int unsigned STAGES    = 1,
    parameter int unsigned CR_STAGES = STAGES,
    parameter int unsigned BUF_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPL*FLIT_W-1:0] up_flit,
    input  logic [NPL-1:0]        up_valid,
    output logic [NPL-1:0]        up_ready,
    output logic [NPL*FLIT_W-1:0] dn_flit,
    output logic [NPL-1:0]        dn_valid,
    input  logic [NPL-1:0]        dn_credit,
    output logic [NPL-1:0]        err
);

    localparam int unsigned   CW       = cnt_width(BUF_LEN);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (STAGES > LINK_MAX_STAGES || CR_STAGES > LINK_MAX_STAGES ||
        BUF_LEN < 1 || NPL < 1 || FLIT_W < 1) begin : g_param_check
        $error("lag_credit_link: parameter out of range");
    end

    for (genvar l = 0; l < NPL; l++) begin : g_lane
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              err_q, err_d;
        logic              accept;
        logic              cr_arrive;
        logic [FLIT_W-1:0] fwd_in;
        logic              cr_data_unused;

        assign up_ready[l] = (cnt_q != '0);
        assign accept      = up_valid[l] & up_ready[l];
        // Zeroing rejected data keeps the STAGES = 0 bypass output at 0 on bubbles.
        assign fwd_in      = accept ? up_flit[l*FLIT_W +: FLIT_W] : '0;

        lag_delay_line #(
            .W     (FLIT_W),
            .DEPTH (STAGES)
        ) u_fwd (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (accept),
            .in_data   (fwd_in),
            .out_valid (dn_valid[l]),
            .out_data  (dn_flit[l*FLIT_W +: FLIT_W])
        );

        lag_delay_line #(
            .W     (0),
            .DEPTH (CR_STAGES)
        ) u_cr (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (dn_credit[l]),
            .in_data   (1'b0),
            .out_valid (cr_arrive),
            .out_data  (cr_data_unused)
        );

        always_comb begin
            cnt_d = cnt_q;
            err_d = err_q;
            if (up_valid[l] && !up_ready[l]) begin
                err_d = 1'b1;
            end
            // Accept and arriving credit together cancel, even at a full counter.
            if (accept && !cr_arrive) begin
                cnt_d = cnt_q - CNT_ONE;
            end else if (cr_arrive && !accept) begin
                if (cnt_q == CNT_FULL) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= CNT_FULL;
                err_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end

        assign err[l] = err_q;
    end

endmodule

// File: tb/tb_lag_credit_link.sv
module tb_lag_credit_link;

    localparam int unsigned FW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // dut_a: STAGES=2, CR_STAGES=3, BUF_LEN=4
    logic [2*FW-1:0] up_flit_a, dn_flit_a;
    logic [1:0]      up_valid_a, up_ready_a, dn_valid_a, dn_credit_a, err_a;
    // dut_b: bypass, BUF_LEN=2, downstream frees a slot in every arrival cycle
    logic [2*FW-1:0] up_flit_b, dn_flit_b;
    logic [1:0]      up_valid_b, up_ready_b, dn_valid_b, dn_credit_b, err_b;
    // dut_c: STAGES=4, CR_STAGES defaulted, BUF_LEN=4
    logic [2*FW-1:0] up_flit_c, dn_flit_c;
    logic [1:0]      up_valid_c, up_ready_c, dn_valid_c, dn_credit_c, err_c;

    assign dn_credit_b = dn_valid_b;

    lag_credit_link #(.NPL(2), .FLIT_W(FW), .STAGES(2), .CR_STAGES(3), .BUF_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .up_flit(up_flit_a), .up_valid(up_valid_a),
        .up_ready(up_ready_a), .dn_flit(dn_flit_a), .dn_valid(dn_valid_a),
        .dn_credit(dn_credit_a), .err(err_a));

    lag_credit_link #(.NPL(2), .FLIT_W(FW), .STAGES(0), .CR_STAGES(0), .BUF_LEN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .up_flit(up_flit_b), .up_valid(up_valid_b),
        .up_ready(up_ready_b), .dn_flit(dn_flit_b), .dn_valid(dn_valid_b),
        .dn_credit(dn_credit_b), .err(err_b));

    lag_credit_link #(.NPL(2), .FLIT_W(FW), .STAGES(4), .BUF_LEN(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .up_flit(up_flit_c), .up_valid(up_valid_c),
        .up_ready(up_ready_c), .dn_flit(dn_flit_c), .dn_valid(dn_valid_c),
        .dn_credit(dn_credit_c), .err(err_c));

    // Each cycle: wait for the falling edge, drive, settle 1 time unit, sample.
    task automatic idle_inputs();
        up_flit_a = '0; up_valid_a = '0; dn_credit_a = '0;
        up_flit_b = '0; up_valid_b = '0;
        up_flit_c = '0; up_valid_c = '0; dn_credit_c = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (up_ready_a !== 2'b11) begin n_fail++; $display("FAIL reset_ready_a got %b want 11", up_ready_a); end
        n_checks++; if (dn_valid_a !== 2'b00) begin n_fail++; $display("FAIL reset_dn_valid_a got %b want 00", dn_valid_a); end
        n_checks++; if (err_a !== 2'b00) begin n_fail++; $display("FAIL reset_err_a got %b want 00", err_a); end
        n_checks++; if (dn_flit_a !== '0) begin n_fail++; $display("FAIL reset_dn_flit_a got %h want 0", dn_flit_a); end
        n_checks++; if (up_ready_b !== 2'b11 || err_b !== 2'b00) begin n_fail++; $display("FAIL reset_b got ready=%b err=%b want 11/00", up_ready_b, err_b); end
        n_checks++; if (up_ready_c !== 2'b11 || dn_valid_c !== 2'b00 || err_c !== 2'b00) begin
            n_fail++; $display("FAIL reset_c got ready=%b dn_valid=%b err=%b want 11/00/00", up_ready_c, dn_valid_c, err_c); end
    endtask

    // Lane 0 of dut_a: A..D accepted back-to-back, 5th send rejected.
    task automatic test_credit_exhaustion();
        logic [FW-1:0] flits [5];
        flits = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C,
                  64'hDDDD_0000_0000_000D, 64'hEEEE_0000_0000_000E};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            up_valid_a = (k < 5) ? 2'b01 : 2'b00;
            up_flit_a  = (k < 5) ? {64'h0, flits[k]} : '0;
            #1;
            n_checks++; if (up_ready_a[0] !== (k < 4)) begin n_fail++; $display("FAIL exh_ready k=%0d got %b want %b", k, up_ready_a[0], (k < 4)); end
            n_checks++; if (dn_valid_a !== ((k >= 2 && k <= 5) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL exh_dn_valid k=%0d got %b", k, dn_valid_a); end
            if (k >= 2 && k <= 5) begin
                n_checks++; if (dn_flit_a[FW-1:0] !== flits[k-2]) begin
                    n_fail++; $display("FAIL exh_dn_flit k=%0d got %h want %h", k, dn_flit_a[FW-1:0], flits[k-2]); end
            end
            n_checks++; if (err_a !== ((k >= 5) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL exh_err k=%0d got %b", k, err_a); end
        end
    endtask

    // Lane 1 of dut_a: drain credits, then one credit pulse through the 3-deep return pipe.
    task automatic test_credit_return();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            up_valid_a = (k < 4) ? 2'b10 : 2'b00;
            up_flit_a  = {64'h1111_0000_0000_0000 + 64'(k), 64'h0};
            #1;
            n_checks++; if (up_ready_a[1] !== (k < 4)) begin n_fail++; $display("FAIL ret_drain k=%0d got %b want %b", k, up_ready_a[1], (k < 4)); end
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            up_valid_a  = 2'b00;
            dn_credit_a = (j == 0) ? 2'b10 : 2'b00;
            #1;
            n_checks++; if (up_ready_a[1] !== (j >= 4)) begin n_fail++; $display("FAIL ret_ready j=%0d got %b want %b", j, up_ready_a[1], (j >= 4)); end
        end
        n_checks++; if (err_a !== 2'b01) begin n_fail++; $display("FAIL ret_err got %b want 01", err_a); end
    endtask

    // Lane 1 of dut_a starts with one credit; refill to full, then accept + arrival together.
    task automatic test_simultaneous();
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            dn_credit_a = (j < 3) ? 2'b10 : 2'b00;
        end
        for (int m = 0; m < 6; m++) begin
            @(negedge clk);
            dn_credit_a = (m == 0) ? 2'b10 : 2'b00;
            up_valid_a  = (m == 3) ? 2'b10 : 2'b00;
            up_flit_a   = {64'h5151_5151_5151_5151, 64'h0};
            #1;
        end
        n_checks++; if (err_a[1] !== 1'b0) begin n_fail++; $display("FAIL simul_err got %b want 0", err_a[1]); end
        n_checks++; if (up_ready_a[1] !== 1'b1) begin n_fail++; $display("FAIL simul_ready got %b want 1", up_ready_a[1]); end
        for (int u = 0; u < 5; u++) begin
            @(negedge clk);
            up_valid_a  = 2'b00;
            dn_credit_a = (u == 0) ? 2'b10 : 2'b00;
            #1;
            n_checks++; if (err_a[1] !== (u >= 4)) begin n_fail++; $display("FAIL overflow_err u=%0d got %b want %b", u, err_a[1], (u >= 4)); end
        end
        dn_credit_a = 2'b00;
        // Counter must still hold exactly BUF_LEN: four accepts, then no credit.
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            up_valid_a = (p < 4) ? 2'b10 : 2'b00;
            #1;
            n_checks++; if (up_ready_a[1] !== (p < 4)) begin n_fail++; $display("FAIL sat_cnt p=%0d got %b want %b", p, up_ready_a[1], (p < 4)); end
        end
        up_valid_a = 2'b00;
    endtask

    task automatic test_bypass();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            up_valid_b = 2'b11;
            up_flit_b  = {64'hB0B0_0000_0000_0000 ^ 64'(k * 3), 64'h0000_0000_1234_0000 + 64'(k)};
            #1;
            n_checks++; if (dn_valid_b !== 2'b11) begin n_fail++; $display("FAIL byp_valid k=%0d got %b want 11", k, dn_valid_b); end
            n_checks++; if (dn_flit_b !== up_flit_b) begin n_fail++; $display("FAIL byp_flit k=%0d got %h want %h", k, dn_flit_b, up_flit_b); end
            n_checks++; if (up_ready_b !== 2'b11 || err_b !== 2'b00) begin
                n_fail++; $display("FAIL byp_ready_err k=%0d got ready=%b err=%b want 11/00", k, up_ready_b, err_b); end
        end
        @(negedge clk);
        up_valid_b = 2'b00;
        up_flit_b  = {64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F};
        #1;
        n_checks++; if (dn_valid_b !== 2'b00 || dn_flit_b !== '0) begin
            n_fail++; $display("FAIL byp_bubble got valid=%b flit=%h want 00/0", dn_valid_b, dn_flit_b); end
        up_flit_b = '0;
    endtask

    task automatic test_midstream_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            up_valid_c = 2'b01;
            up_flit_c  = {64'h0, 64'hC0DE_0000_0000_0000 + 64'(k)};
        end
        @(negedge clk);
        up_valid_c = 2'b00;
        up_flit_c  = '0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (dn_valid_c !== 2'b00 || up_ready_c !== 2'b11 || err_c !== 2'b00) begin
            n_fail++; $display("FAIL mrst_state got valid=%b ready=%b err=%b want 00/11/00", dn_valid_c, up_ready_c, err_c); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++; if (dn_valid_c !== 2'b00) begin n_fail++; $display("FAIL mrst_leak k=%0d got %b want 00", k, dn_valid_c); end
        end
        // Counter reloaded to BUF_LEN: exactly four accepts before ready drops.
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            up_valid_c = (p < 4) ? 2'b01 : 2'b00;
            #1;
            n_checks++; if (up_ready_c[0] !== (p < 4)) begin n_fail++; $display("FAIL mrst_cnt p=%0d got %b want %b", p, up_ready_c[0], (p < 4)); end
        end
        up_valid_c = 2'b00;
    endtask

    initial begin
        test_reset();
        test_credit_exhaustion();
        test_credit_return();
        test_simultaneous();
        test_bypass();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
